vec_chunk_buffer: RTL
=====================

# vec_chunk_buffer

- Ping-pong vector buffer sitting directly upstream of the matrix-vector product stage.
- Collects a signed 8-bit element stream from the previous layer into complete input vectors.
- Presents each vector to the consumer as WorkingRegs-wide chunks through the consumer's chunk-request protocol: advance, rewind, release.
- A second bank lets the next vector fill while the current one is re-read once per output row.

## Interface
- VecLength, 16, elements per vector; must be a multiple of WorkingRegs, ≥ 2·WorkingRegs.
- WorkingRegs, 4, elements per chunk; width of the consumer datapath.
- clk_in  in  1  clock; all logic on the rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- wr_valid  in  1  producer presents an element.
- wr_data  in  8 signed  element value.
- wr_ready  out  1  buffer can accept an element this cycle.
- in_data_ready  out  1  a complete vector is readable.
- in_data  out  [WorkingRegs-1:0][7:0] signed  chunk at the read pointer.
- req_chunk_in  in  1  advance read pointer one chunk.
- req_chunk_ptr_rst  in  1  rewind read pointer to chunk 0.
- vec_release  in  1  consumer finished with the current vector.
- vec_count  out  2  number of full banks (0..2).
- overflow  out  1  sticky: element offered while wr_ready low.

## Operation
- Storage: banks 0/1, each VecLength bytes, plus per-bank state EMPTY → FILLING → FULL → EMPTY.
- Write pointers:
  - wr_bank: bank being filled.
  - wr_cnt: 0..VecLength-1.
- Read pointers:
  - rd_bank: bank being read.
  - rd_ptr: 0..VecLength/WorkingRegs-1.
- wr_ready = (state[wr_bank] != FULL).
- Accept (wr_valid & wr_ready):
  - Store at element index wr_cnt; EMPTY → FILLING.
  - When wr_cnt = VecLength-1: FULL, wr_cnt ← 0, wr_bank toggles.
- Accepting with wr_cnt = 0 and wr_cnt = VecLength-1 in the same element (VecLength=1) is not supported; the parameter rule forbids it.
- in_data_ready = (state[rd_bank] == FULL).
- in_data ordering, driven combinationally from registers: in_data[WorkingRegs-1-j] = element rd_ptr·WorkingRegs + j. Earliest element sits in the top lane.
- Read-pointer update, in priority order:
  - req_chunk_ptr_rst: rd_ptr ← 0. Wins over req_chunk_in.
  - Else req_chunk_in: rd_ptr ← rd_ptr+1, wrapping last chunk → 0.
- Both read-pointer requests act regardless of in_data_ready.
- vec_release with in_data_ready high:
  - state[rd_bank] ← EMPTY, rd_bank toggles, rd_ptr ← 0.
  - Ignored when in_data_ready is low.
- Release and a completing write in the same cycle touch different banks by construction; both take effect.
- vec_count = number of banks in FULL.
- overflow sets on wr_valid & !wr_ready and holds until reset; the element is dropped.

## Timing
- Reset (rst_in low, asynchronous):
  - Cleared: banks EMPTY, wr_bank, rd_bank, wr_cnt, rd_ptr, overflow, all storage = 0.
  - Resulting outputs: wr_ready=1, in_data_ready=0, in_data=0, vec_count=0.
- Reset mid-fill or mid-read discards all data; no partial vector survives.
- Write-to-ready latency: last element accepted at edge N → in_data_ready high in cycle after N, if that bank is rd_bank. Otherwise high one cycle after the release that makes it rd_bank.
- Read latency:
  - in_data is valid in the same cycle the pointer changes, i.e. zero-latency combinational read.
  - req_chunk_in sampled at edge N → in_data shows the next chunk after N.
- Release sampled at edge N:
  - in_data_ready after N reflects the other bank; high immediately if that bank is already FULL (back-to-back vectors, no bubble).
  - wr_ready rises after N if the write side was stalled on the released bank.
- Sustained throughput: one element per cycle on write; one chunk per cycle on read.

## Configuration
- VEC_CHUNK_BUF_PINGPONG_EN defined: two banks as above; vec_count 0..2.
- Undefined: single bank only.
  - wr_bank and rd_bank are constant 0.
  - wr_ready low from vector complete until vec_release.
  - vec_count 0..1, upper bit tied 0.
  - All other behaviour identical.

## Test plan
All scenarios use VecLength=8, WorkingRegs=4, ping-pong enabled unless stated.
- Fill and read: write 1..8 → in_data_ready=1, in_data={1,2,3,4} (lane3=1); req_chunk_in → {5,6,7,8}; req_chunk_in again → wraps to {1,2,3,4}.
- Rewind precedence: at chunk 1, assert req_chunk_ptr_rst and req_chunk_in together → rd_ptr=0, in_data={1,2,3,4}.
- Back-to-back vectors: write 1..8 then 11..18 → vec_count=2, wr_ready=0; vec_release → next cycle in_data={11,12,13,14}, in_data_ready stays 1, vec_count=1, wr_ready=1.
- Overflow: with both banks full, pulse wr_valid with wr_data=99 → overflow=1 and stays 1; after release and reading, 99 never appears.
- Spurious release: vec_release while in_data_ready=0 → no change to rd_bank, vec_count, or pointers.
- Async reset mid-fill: drop rst_in after 3 writes, between edges → outputs cleared immediately; then write 1..8 → in_data={1,2,3,4}. Repeat with macro undefined: wr_ready=0 after 8 writes until release.

Source files
------------

// File: rtl/vec_chunk_buffer.sv
// Ping-pong vector buffer: packs an int8 element stream into vectors and
// serves them as WorkingRegs-wide chunks (advance / rewind / release).
// Ports: clk_in, rst_in (async low); wr_valid/wr_data/wr_ready element input;
// in_data_ready/in_data chunk output; req_chunk_in, req_chunk_ptr_rst,
// vec_release consumer requests; vec_count full banks; overflow sticky drop.
// Build option: VEC_CHUNK_BUF_PINGPONG_EN enables the second bank.
module vec_chunk_buffer #(
  parameter int VecLength   = 16,
  parameter int WorkingRegs = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               wr_valid,
  input  logic signed [7:0]                  wr_data,
  output logic                               wr_ready,
  output logic                               in_data_ready,
  output logic signed [WorkingRegs-1:0][7:0] in_data,
  input  logic                               req_chunk_in,
  input  logic                               req_chunk_ptr_rst,
  input  logic                               vec_release,
  output logic [1:0]                         vec_count,
  output logic                               overflow
);

`ifdef VEC_CHUNK_BUF_PINGPONG_EN
  localparam bit PingPong = 1'b1;
`else
  localparam bit PingPong = 1'b0;
`endif

  localparam int NumChunks = VecLength / WorkingRegs;
  localparam int CW = $clog2(VecLength);
  localparam int PW = $clog2(NumChunks);
  localparam logic [CW-1:0] LastElem = CW'(VecLength - 1);
  localparam logic [PW-1:0] LastChunk = PW'(NumChunks - 1);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_t;

  bank_state_t       state_q [2];
  bank_state_t       state_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic signed [7:0] mem [2][VecLength];
  logic              accept;
  logic              release_ok;

  assign wr_ready      = (state_q[wr_bank_q] != FULL);
  assign in_data_ready = (state_q[rd_bank_q] == FULL);
  assign accept        = wr_valid & wr_ready;
  assign release_ok    = vec_release & in_data_ready;

  // Single-bank build never lets bank 1 go FULL; the tie keeps
  // the upper bit a structural zero.
  assign vec_count = PingPong
    ? (2'(state_q[0] == FULL) + 2'(state_q[1] == FULL))
    : {1'b0, state_q[0] == FULL};

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    if (accept) begin
      if (wr_cnt_q == LastElem) begin
        state_d[wr_bank_q] = FULL;
        wr_cnt_d  = '0;
        wr_bank_d = PingPong ? ~wr_bank_q : 1'b0;
      end else begin
        state_d[wr_bank_q] = FILLING;
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    if (req_chunk_ptr_rst) begin
      rd_ptr_d = '0;
    end else if (req_chunk_in) begin
      rd_ptr_d = (rd_ptr_q == LastChunk) ? '0 : rd_ptr_q + 1'b1;
    end
    // A completing write always targets the other bank, so both
    // updates to state_d can land in the same cycle.
    if (release_ok) begin
      state_d[rd_bank_q] = EMPTY;
      rd_bank_d = PingPong ? ~rd_bank_q : 1'b0;
      rd_ptr_d  = '0;
    end
  end

  // Earliest element of the chunk lands in the top lane.
  always_comb begin
    in_data = '0;
    for (int j = 0; j < WorkingRegs; j++) begin
      in_data[WorkingRegs-1-j] =
        mem[rd_bank_q][CW'(int'(rd_ptr_q) * WorkingRegs + j)];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      overflow   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < VecLength; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      if (wr_valid && !wr_ready) begin
        overflow <= 1'b1;
      end
      if (accept) begin
        mem[wr_bank_q][wr_cnt_q] <= wr_data;
      end
    end
  end

endmodule
